// File: rtl/sparc_tlu_penc64_q_if.sv
// Handshake bundle for the 64-entry pending-event priority encoder.
// The master side posts set/flush/ack; the slave side presents vld/idx and the pending state.
interface sparc_tlu_penc64_q_if;
    logic [63:0] set_vec;
    logic        flush;
    logic        ack;
    logic        vld;
    logic [5:0]  idx;
    logic [63:0] pend_vec;
    logic        pend_any;

    modport master (
        output set_vec, flush, ack,
        input  vld, idx, pend_vec, pend_any
    );

    modport slave (
        input  set_vec, flush, ack,
        output vld, idx, pend_vec, pend_any
    );
endinterface

// File: rtl/sparc_tlu_penc64_q.sv
// Pending-event queue with lowest-index-first presentation; set->vld latency 2 edges.
// Holds vld/idx until ack (no preemption); each retire adds a one-cycle bubble.
module sparc_tlu_penc64_q (
    input logic                    rclk,
    input logic                    rst,
    sparc_tlu_penc64_q_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, PRESENT, RETIRE} state_t;

    state_t      state;
    logic [63:0] pend_r;
    logic [63:0] pend_nxt;
    logic [63:0] onehot;
    logic [63:0] clr;
    logic [63:0] cand;
    logic [5:0]  enc;
    logic [5:0]  idx_r;
    logic        vld_r;
    logic        any_r;

    assign onehot = 64'h1 << idx_r;

    // The presented bit is never a candidate while it is still being shown.
    assign cand = pend_r & ~((state == PRESENT) ? onehot : 64'h0);

    always_comb begin
        enc = 6'h00;
        for (int i = 63; i >= 0; i--) begin
            if (cand[i]) enc = i[5:0];
        end
    end

    // Set is OR'd in after the retire clear so a colliding set survives.
    always_comb begin
        clr      = (state == PRESENT && bus.ack) ? onehot : 64'h0;
        pend_nxt = bus.flush ? 64'h0 : ((pend_r & ~clr) | bus.set_vec);
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pend_r <= 64'h0;
            any_r  <= 1'b0;
            vld_r  <= 1'b0;
            idx_r  <= 6'h00;
        end else begin
            pend_r <= pend_nxt;
            any_r  <= |pend_nxt;
            if (bus.flush) begin
                state <= IDLE;
                vld_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (|pend_r) begin
                            state <= PRESENT;
                            vld_r <= 1'b1;
                            idx_r <= enc;
                        end
                    end
                    PRESENT: begin
                        if (bus.ack) begin
                            state <= RETIRE;
                            vld_r <= 1'b0;
                        end
                    end
                    RETIRE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        vld_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.vld      = vld_r;
    assign bus.idx      = idx_r;
    assign bus.pend_vec = pend_r;
    assign bus.pend_any = any_r;
endmodule

// File: doc/sparc_tlu_penc64_q.md
SPARC_TLU_PENC64_Q -- requirements
Module: sparc_tlu_penc64_q

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: rclk is the clock and rst is the reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- rclk  in  1  clock, all state on rising edge.
- rst  in  1  async active-high reset.
- set_vec  in  64  one-cycle set pulses; bit i marks event i pending.
- flush  in  1  synchronous clear of all pending state.
- ack  in  1  consumer accepts the presented index.
- vld  out  1  idx valid, registered.
- idx  out  6  encoded event number, registered.
- pend_vec  out  64  current pending register.
- pend_any  out  1  OR of pend_vec, registered.

Function
REQ-003 The block SHALL hold a 64-bit pending register; set_vec bit i SHALL set pend_vec[i] on the following edge.
REQ-004 Encoding SHALL select the lowest-numbered set bit of pend_vec, excluding the bit currently presented (see REQ-009); idx = that bit number (0..63).
REQ-005 The FSM states SHALL be IDLE, PRESENT and RETIRE, with these outputs:
- IDLE: vld=0.
- PRESENT: vld=1, idx frozen.
- RETIRE: vld=0, one-cycle bubble.
REQ-006 The transitions out of IDLE SHALL be:
- IDLE->PRESENT when pend_vec != 0 at the clock edge.
- idx is loaded with the encode result on that same edge.
REQ-007 Latency from set_vec pulse at edge N (empty queue, IDLE) SHALL be: pend_vec bit visible after edge N, vld=1 with idx after edge N+1.
REQ-008 While in PRESENT, idx and vld SHALL stay stable until ack=1, even if a lower-numbered bit becomes pending (no preemption).
REQ-009 The transitions out of PRESENT SHALL be:
- PRESENT with ack=1 -> RETIRE.
- On that edge pend_vec[idx] is cleared, using an internal 6->64 one-hot decode of idx.
REQ-010 Simultaneous set_vec[idx]=1 and ack SHALL leave pend_vec[idx]=1 (set wins); that event is presented again later.
REQ-011 RETIRE SHALL go to IDLE unconditionally after one cycle; back-to-back presentations are therefore spaced by at least 2 cycles of vld=0... minimum vld low time is 1 cycle (RETIRE) plus IDLE evaluation.
REQ-012 ack SHALL be ignored when vld=0 (IDLE, RETIRE): no bit is cleared and no state changes.
REQ-013 flush=1 SHALL, on the next edge:
- clear pend_vec to 0, and set_vec in the same cycle is discarded;
- force the FSM to IDLE and vld=0;
- take precedence over ack and set_vec.
REQ-014 pend_any SHALL equal the registered OR of the next pend_vec value, so pend_any and pend_vec update together.
REQ-015 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from input to output.
REQ-016 idx SHALL hold its last value when vld=0; consumers SHALL NOT use it unless vld=1.

Reset
REQ-017 Asserting rst SHALL immediately (asynchronously) force all of the following:
- pend_vec=64'h0;
- FSM=IDLE;
- vld=0, idx=6'h00, pend_any=0.
REQ-018 After rst deasserts, the first set_vec pulse SHALL be captured on the first rising edge.
REQ-019 Reset asserted mid-PRESENT SHALL drop vld without requiring ack; the pending event is lost.

Verification
REQ-020 Single event: set_vec=64'h0000_0000_0000_0020 for 1 cycle -> pend_vec bit 5 next cycle; vld=1, idx=6'h05 the cycle after; ack -> pend_vec=0, vld=0.
REQ-021 Priority/no preemption: pend bits 63 and 40; present idx=6'h28; pulse bit 3 while vld=1, no ack -> idx stays 6'h28; after ack, next idx=6'h03, then 6'h3f.
REQ-022 Set-wins collision: vld=1, idx=6'h00; assert ack with set_vec bit 0 in the same cycle -> pend_vec[0] remains 1; idx=6'h00 is presented again after RETIRE/IDLE.
REQ-023 Flush: pend_vec=64'hFFFF_FFFF_FFFF_FFFF, vld=1; flush with ack and set_vec=64'h1 -> next cycle pend_vec=0, pend_any=0, vld=0.
REQ-024 Stray ack and reset: ack pulses while vld=0 -> pend_vec unchanged; async rst mid-PRESENT -> vld=0, idx=6'h00, pend_vec=0 without waiting for rclk.
REQ-025 Exhaustive drain: set all 64 bits in one cycle -> idx sequence 0,1,...,63 with each presentation acked immediately, then vld stays 0 and pend_any=0.
